// File: rtl/dmem_wbuf.sv
// Data memory for the load/store port: word RAM behind a coalescing write buffer.
// Define DMEM_WBUF_STATS_EN to add saturating fwd_hits/drains/coalesces counters.

module dmem_wbuf_ent #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic          upd,
  input  logic          clr,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] qaddr,
  output logic          vld,
  output logic [AW-1:0] addr,
  output logic [31:0]   data,
  output logic          hit
);
  assign hit = vld && (addr == qaddr);

  // A push into the slot being drained (forced drain) must win over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld  <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (ld) begin
      vld  <= 1'b1;
      addr <= waddr;
      data <= wdata;
    end else begin
      if (upd) data <= wdata;
      if (clr) vld  <= 1'b0;
    end
  end
endmodule

module dmem_wbuf #(
  parameter int ADDR_W   = 8,
  parameter int WB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 A,
  input  logic [31:0]                 WD,
  input  logic                        WE,
  input  logic                        RE,
  output logic [31:0]                 RD,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
`ifdef DMEM_WBUF_STATS_EN
  output logic [15:0]                 fwd_hits,
  output logic [15:0]                 drains,
  output logic [15:0]                 coalesces,
`endif
  output logic                        wb_full
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] widx;
  logic              unused_a;
  assign widx     = A[ADDR_W+1:2];
  assign unused_a = ^{A[31:ADDR_W+2], A[1:0]};

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          full, empty;

  logic [WB_DEPTH-1:0]              ent_vld, ent_hit, ent_ld, ent_upd, ent_clr;
  logic [WB_DEPTH-1:0][ADDR_W-1:0]  ent_addr;
  logic [WB_DEPTH-1:0][31:0]        ent_data;

  logic        any_hit, coalesce, push, forced, idle, drain;
  logic [31:0] fwd;

  logic [31:0] mem [0:(2**ADDR_W)-1];

  assign full     = (count == CW'(WB_DEPTH));
  assign empty    = (count == '0);
  assign any_hit  = |ent_hit;
  assign coalesce = WE && any_hit;
  assign push     = WE && !any_hit;
  assign forced   = push && full;
  assign idle     = !WE && !RE && !empty;
  assign drain    = forced || idle;

  genvar i;
  generate
    for (i = 0; i < WB_DEPTH; i++) begin : g_ent
      assign ent_ld[i]  = push && (tail == PW'(i));
      assign ent_upd[i] = coalesce && ent_hit[i];
      assign ent_clr[i] = drain && (head == PW'(i));

      dmem_wbuf_ent #(.AW(ADDR_W)) u_ent (
        .clk   (clk),
        .reset (reset),
        .ld    (ent_ld[i]),
        .upd   (ent_upd[i]),
        .clr   (ent_clr[i]),
        .waddr (widx),
        .wdata (WD),
        .qaddr (widx),
        .vld   (ent_vld[i]),
        .addr  (ent_addr[i]),
        .data  (ent_data[i]),
        .hit   (ent_hit[i])
      );
    end
  endgenerate

  // Coalescing keeps at most one hit, so an OR-reduce is a safe mux.
  always_comb begin
    fwd = '0;
    for (int k = 0; k < WB_DEPTH; k++)
      if (ent_hit[k]) fwd = fwd | ent_data[k];
  end

  assign RD       = any_hit ? fwd : mem[widx];
  assign wb_count = count;
  assign wb_full  = full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (drain) head <= head + 1'b1;
      if (push)  tail <= tail + 1'b1;
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Array is never cleared; drain is gated by count, which is 0 in reset.
  always_ff @(posedge clk) begin
    if (drain) mem[ent_addr[head]] <= ent_data[head];
  end

`ifdef DMEM_WBUF_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_hits  <= '0;
      drains    <= '0;
      coalesces <= '0;
    end else begin
      if (RE && any_hit && fwd_hits != 16'hFFFF)   fwd_hits  <= fwd_hits + 1'b1;
      if (drain && drains != 16'hFFFF)             drains    <= drains + 1'b1;
      if (coalesce && coalesces != 16'hFFFF)       coalesces <= coalesces + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_wbuf.sv
// Self-checking bench for dmem_wbuf: directed table, corner sequences, random vs queue model.

module tb_dmem_wbuf;
  logic        clk, reset;
  logic [31:0] A, WD, RD;
  logic        WE, RE;
  logic [2:0]  wb_count;
  logic        wb_full;
`ifdef DMEM_WBUF_STATS_EN
  logic [15:0] fwd_hits, drains, coalesces;
`endif

  dmem_wbuf #(.ADDR_W(8), .WB_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .WD        (WD),
    .WE        (WE),
    .RE        (RE),
    .RD        (RD),
    .wb_count  (wb_count),
`ifdef DMEM_WBUF_STATS_EN
    .fwd_hits  (fwd_hits),
    .drains    (drains),
    .coalesces (coalesces),
`endif
    .wb_full   (wb_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Reference model: FIFO queue of pending stores plus a shadow array.
  typedef struct { logic [7:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic [31:0] mem_m [256];
  bit          known [256];
  int          m_fwd = 0, m_drn = 0, m_coal = 0;

  task automatic model_rd(input logic [31:0] a, output bit ok, output logic [31:0] v);
    logic [7:0] w;
    w  = a[9:2];
    ok = known[w];
    v  = mem_m[w];
    foreach (q[k]) if (q[k].a == w) begin ok = 1; v = q[k].d; end
  endtask

  task automatic model_edge(input bit we, input bit re, input logic [31:0] a, input logic [31:0] wd);
    logic [7:0] w;
    int hit;
    ent_t e;
    w = a[9:2];
    hit = -1;
    foreach (q[k]) if (q[k].a == w) hit = k;
    if (re && hit >= 0) m_fwd++;
    if (we) begin
      if (hit >= 0) begin q[hit].d = wd; m_coal++; end
      else begin
        if (q.size() == 4) begin
          e = q.pop_front(); mem_m[e.a] = e.d; known[e.a] = 1; m_drn++;
        end
        e.a = w; e.d = wd; q.push_back(e);
      end
    end else if (!re && q.size() > 0) begin
      e = q.pop_front(); mem_m[e.a] = e.d; known[e.a] = 1; m_drn++;
    end
  endtask

  // Called at negedge; samples RD before the edge and count/full after it.
  task automatic step(input bit we, input bit re, input logic [31:0] a, input logic [31:0] wd,
                      input bit do_chk, output logic [31:0] rd_s);
    bit ok;
    logic [31:0] v;
    WE = we; RE = re; A = a; WD = wd;
    #1;
    rd_s = RD;
    if (do_chk) begin
      model_rd(a, ok, v);
      if (ok) chk("rd", RD, v);
    end
    @(posedge clk);
    model_edge(we, re, a, wd);
    @(negedge clk);
    if (do_chk) begin
      chk("wb_count", 32'(wb_count), 32'(q.size()));
      chk("wb_full", 32'(wb_full), 32'(q.size() == 4));
    end
  endtask

  typedef struct {
    bit we, re, crd;
    logic [31:0] a, wd, rd;
    int cnt;
  } vec_t;
  vec_t tbl[13];

  function automatic vec_t mk(bit we, bit re, logic [31:0] a, logic [31:0] wd, bit crd,
                              logic [31:0] rd, int cnt);
    vec_t t;
    t.we = we; t.re = re; t.a = a; t.wd = wd; t.crd = crd; t.rd = rd; t.cnt = cnt;
    return t;
  endfunction

  initial begin
    logic [31:0] r, a;
    int mode;
    tbl[0]  = mk(1, 0, 32'h10, 32'hAAAA0001, 0, 0, 1);
    tbl[1]  = mk(1, 0, 32'h14, 32'hBBBB0002, 0, 0, 2);
    tbl[2]  = mk(1, 0, 32'h18, 32'hCCCC0003, 0, 0, 3);
    tbl[3]  = mk(0, 1, 32'h14, 0, 1, 32'hBBBB0002, 3);
    tbl[4]  = mk(0, 0, 32'h10, 0, 1, 32'hAAAA0001, 2);
    tbl[5]  = mk(0, 0, 32'h14, 0, 1, 32'hBBBB0002, 1);
    tbl[6]  = mk(0, 0, 32'h18, 0, 1, 32'hCCCC0003, 0);
    tbl[7]  = mk(0, 1, 32'h14, 0, 1, 32'hBBBB0002, 0);
    tbl[8]  = mk(1, 0, 32'h20, 32'h11111111, 0, 0, 1);
    tbl[9]  = mk(1, 0, 32'h20, 32'h22222222, 1, 32'h11111111, 1);
    tbl[10] = mk(0, 1, 32'h20, 0, 1, 32'h22222222, 1);
    tbl[11] = mk(0, 0, 32'h20, 0, 1, 32'h22222222, 0);
    tbl[12] = mk(0, 1, 32'h10, 0, 1, 32'hAAAA0001, 0);

    reset = 1'b0; WE = 0; RE = 0; A = 0; WD = 0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(wb_count), 0);
    chk("rst_full", 32'(wb_full), 0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd, 0, r);
      if (tbl[i].crd) chk($sformatf("tbl%0d_rd", i), r, tbl[i].rd);
      chk($sformatf("tbl%0d_cnt", i), 32'(wb_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_full", i), 32'(wb_full), 32'(tbl[i].cnt == 4));
    end
`ifdef DMEM_WBUF_STATS_EN
    chk("stat_coal", 32'(coalesces), 1);
    chk("stat_fwd", 32'(fwd_hits), 2);
    chk("stat_drn", 32'(drains), 4);
`endif

    // Forced drain on a full buffer.
    for (int i = 0; i < 4; i++) step(1, 0, 32'h100 + 32'(4*i), 32'h5000_0000 + 32'(i), 1, r);
    chk("fill_full", 32'(wb_full), 1);
    step(1, 0, 32'h40, 32'h55, 1, r);
    chk("force_full", 32'(wb_full), 1);
    chk("force_cnt", 32'(wb_count), 4);
    step(0, 1, 32'h100, 0, 1, r);
    chk("force_old_rd", r, 32'h5000_0000);
    step(0, 1, 32'h40, 0, 1, r);
    chk("force_new_rd", r, 32'h55);
    repeat (4) step(0, 0, 32'h0, 0, 1, r);

    // Loads hold off the drain; idle cycles then drain one entry each.
    step(1, 0, 32'h200, 32'hD00D0001, 1, r);
    step(1, 0, 32'h204, 32'hD00D0002, 1, r);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 32'h0, 0, 1, r);
      chk("re_hold_cnt", 32'(wb_count), 2);
    end
    step(0, 0, 32'h0, 0, 1, r);
    chk("idle1_cnt", 32'(wb_count), 1);
    step(0, 0, 32'h0, 0, 1, r);
    chk("idle2_cnt", 32'(wb_count), 0);
    step(0, 1, 32'h200, 0, 1, r);
    chk("drained0", r, 32'hD00D0001);
    step(0, 1, 32'h204, 0, 1, r);
    chk("drained1", r, 32'hD00D0002);

    // Asynchronous reset discards pending stores.
    for (int i = 0; i < 3; i++) step(1, 0, 32'h100 + 32'(4*i), 32'hBAD0_0000 + 32'(i), 1, r);
    WE = 0; RE = 1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("arst_cnt", 32'(wb_count), 0);
    chk("arst_full", 32'(wb_full), 0);
    for (int i = 0; i < 3; i++) begin
      A = 32'h100 + 32'(4*i);
      #1 chk("arst_rd", RD, 32'h5000_0000 + 32'(i));
    end
    q.delete();
    m_fwd = 0; m_drn = 0; m_coal = 0;
    @(negedge clk);
    reset = 1'b1;
`ifdef DMEM_WBUF_STATS_EN
    chk("arst_stat", 32'({fwd_hits, drains}), 0);
`endif

    // Address aliasing: upper bits and A[1:0] are ignored.
    step(1, 0, 32'h3FC, 32'hFEED0001, 1, r);
    step(0, 1, 32'hABCDE3FF, 0, 1, r);
    chk("alias_fwd", r, 32'hFEED0001);
    step(0, 0, 32'h0, 0, 1, r);
    step(0, 1, 32'h000007FC, 0, 1, r);
    chk("alias_arr", r, 32'hFEED0001);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      mode = int'($urandom_range(0, 3));
      a = $urandom();
      a[9:2] = 8'h30 + 8'($urandom_range(0, 9));
      case (mode)
        0, 1: step(1, mode == 1, a, $urandom(), 1, r);
        2:    step(0, 1, a, 0, 1, r);
        default: step(0, 0, a, 0, 1, r);
      endcase
    end
`ifdef DMEM_WBUF_STATS_EN
    chk("rnd_fwd", 32'(fwd_hits), 32'(m_fwd));
    chk("rnd_drn", 32'(drains), 32'(m_drn));
    chk("rnd_coal", 32'(coalesces), 32'(m_coal));
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
- Data-memory responder for the single-cycle ARM core's load/store port, on the memory side of the Address/WriteData/MemWrite/ReadData interface.
- Word-addressed RAM array fronted by a small coalescing write buffer.
- Loads return data combinationally in the same cycle. Store data is forwarded from the buffer when present.
- Buffered stores drain into the single-ported array on idle cycles.

Parameters:
ADDR_W, 8, word-address bits; array holds 2**ADDR_W 32-bit words
WB_DEPTH, 4, write-buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
A  input  32  byte address from core ALUResult; word index = A[ADDR_W+1:2]; A[1:0] ignored
WD  input  32  store data (core WriteData)
WE  input  1  store strobe (core MemWrite)
RE  input  1  load strobe (core MemtoReg)
RD  output  32  load data, combinational from A
wb_count  output  $clog2(WB_DEPTH)+1  valid entries in write buffer
wb_full  output  1  wb_count == WB_DEPTH

Behaviour:
- Reset (reset==0, async):
  - All buffer entries invalid; head/tail pointers 0; wb_count=0; wb_full=0.
  - Array contents are not cleared.
  - Entries pending at reset assertion are discarded, including mid-drain.
  - RD then reflects the array only.
- Buffer is a circular FIFO of {valid, word_addr, data}; head = oldest entry.
- RD, combinational:
  - If any valid entry matches A's word index, RD = that entry's data. Coalescing guarantees at most one match.
  - Otherwise RD = array[word index].
  - RD is valid regardless of RE; RE only affects drain arbitration.
- Store (WE=1) at rising edge, buffer not full:
  - Matching valid entry exists: overwrite its data in place (coalesce). wb_count unchanged.
  - No match: push at tail; tail+1 mod WB_DEPTH; wb_count+1.
- Store, buffer full, no match (forced drain):
  - Head entry is written to the array; head advances.
  - New entry pushed at the freed slot; wb_count stays WB_DEPTH.
- Store, buffer full, match: coalesce only; no drain.
- Idle cycle (WE=0 and RE=0), buffer non-empty:
  - Head entry written to the array; entry invalidated; head+1; wb_count-1.
  - One entry per idle cycle.
- Load cycle (RE=1, WE=0): no drain; array port reserved for the read.
- WE=1 and RE=1 together: treated as a store; no idle drain.
- Store data becomes visible on RD (via forwarding) in the cycle after the WE edge. It is never lost until reset.
- Pointers wrap modulo WB_DEPTH.
- wb_count never exceeds WB_DEPTH and never underflows.

Optional Feature:
- Macro DMEM_WBUF_STATS_EN. When defined, adds three outputs:
  - fwd_hits [15:0]: increments on each clk edge where RE=1 and RD came from a buffer entry.
  - drains [15:0]: increments on every array write from the buffer, idle or forced.
  - coalesces [15:0]: increments on each coalesced store.
- All three counters saturate at 16'hFFFF and reset to 0 on reset==0.
- Without the macro: ports and counters absent; core behaviour identical.

Test Plan:
- Reset, then three stores (0x10=0xAAAA0001, 0x14=0xBBBB0002, 0x18=0xCCCC0003) back-to-back:
  - wb_count=3.
  - A=0x14 with RE=1 -> RD=0xBBBB0002 while the array still holds its old value.
- Store 0x20=0x11111111 then 0x20=0x22222222:
  - wb_count=1 after both.
  - RD at A=0x20 = 0x22222222.
  - With DMEM_WBUF_STATS_EN, coalesces=1.
- Fill 4 distinct addresses, then 5th store to 0x40=0x55:
  - wb_full stays 1; oldest entry now in the array.
  - RD at first address equals the stored value (array path).
  - RD at 0x40 = 0x55.
- Fill 2 entries, hold RE=1 for 5 cycles -> wb_count stays 2. Then WE=RE=0 for 2 cycles -> wb_count 1, then 0; array contents match the stored values.
- Fill 3 entries, pulse reset low mid-cycle (asynchronously):
  - wb_count=0 immediately.
  - RD at those addresses returns the pre-store array values.
- Load at 0x3FC with A[31:10] nonzero and ADDR_W=8 -> same word as index 0xFF; address aliasing wraps.
